truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_sweep_pkg.sv | 20 ++
 rtl/truth_table_sweeper_resp_sync.sv | 26 ++
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// sample/synchronizer depths and the majority vote used to resolve each row.
package truth_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int SAMPLES     = 3;
    localparam int SYNC_STAGES = 2;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_resp_sync.sv
// Multi-flop synchronizer bringing the gate response into the clk domain.
// Reset clears every stage so the sweeper never sees a stale response.
module resp_sync
    import truth_sweep_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input row of an N_IN-input gate, waits for it to settle,
// samples the synchronized output three times and reports the truth table.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        stim,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   tt_code,
    output logic [(1<<N_IN)-1:0]   unstable,
    output logic                   tt_valid
);

    localparam int              ROWS        = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_ROW    = '1;
    // Settle window covers the synchronizer latency on top of the gate settle time.
    localparam logic [8:0]      SETTLE_LAST = 9'(SETTLE_CYC + 1);
    localparam logic [8:0]      SAMPLE_LAST = 9'(SAMPLES - 1);

    state_t               state;
    logic [N_IN-1:0]      row;
    logic [8:0]           cnt;
    logic [SAMPLES-2:0]   smp;
    logic [ROWS-1:0]      acc_code;
    logic [ROWS-1:0]      acc_unst;
    logic                 resp_s;
    logic [SAMPLES-1:0]   smp_all;
    logic [N_IN-1:0]      row_bit;

    resp_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (resp),
        .q     (resp_s)
    );

    assign smp_all = {smp, resp_s};
    // Row r lands in bit ROWS-1-r, which for an N_IN-bit row is just its inverse.
    assign row_bit = ~row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            row      <= '0;
            cnt      <= '0;
            smp      <= '0;
            acc_code <= '0;
            acc_unst <= '0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt_code  <= '0;
            unstable <= '0;
            tt_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state    <= ST_IDLE;
                stim     <= '0;
                busy     <= 1'b0;
                tt_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state    <= ST_DRIVE;
                            row      <= '0;
                            stim     <= '0;
                            busy     <= 1'b1;
                            tt_valid <= 1'b0;
                            acc_code <= '0;
                            acc_unst <= '0;
                        end
                    end
                    ST_DRIVE: begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LAST;
                    end
                    ST_SETTLE: begin
                        if (cnt == '0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            cnt <= cnt - 9'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        smp <= smp_all[SAMPLES-2:0];
                        if (cnt == SAMPLE_LAST) begin
                            cnt               <= '0;
                            acc_code[row_bit] <= maj3(smp_all);
                            acc_unst[row_bit] <= !((&smp_all) || !(|smp_all));
                            if (row == LAST_ROW) begin
                                state <= ST_DONE;
                                stim  <= '0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_DRIVE;
                                row   <= row + 1'b1;
                                stim  <= row + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        tt_code  <= acc_code;
                        unstable <= acc_unst;
                        tt_valid <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        stim  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for the truth-table sweeper driving NAND3/AND3/constant gate
// models, a sample glitch, aborts, ignored restarts and asynchronous reset.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] stim;
    logic       resp;
    logic       busy;
    logic       done;
    logic [7:0] tt_code;
    logic [7:0] unstable;
    logic       tt_valid;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;   // 0 NAND3, 1 AND3, 2 tied 1, 3 tied 0
    logic glitch  = 1'b0;
    int   dcyc;
    int   dcnt;

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .stim     (stim),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .tt_code  (tt_code),
        .unstable (unstable),
        .tt_valid (tt_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        resp = 1'b0;
        case (mode)
            0: resp = ~&stim;
            1: resp = &stim;
            2: resp = 1'b1;
            default: resp = 1'b0;
        endcase
        if (glitch) resp = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c=1 is the DRIVE cycle after the accepting edge; DONE is expected at c=81.
    task automatic run_sweep(input int glitch_cyc, input int restart_cyc, input int abort_cyc,
                             output int done_cyc, output int done_cnt);
        done_cyc = -1;
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 1) begin
                chk("busy_at_drive", 32'(busy), 32'd1);
                chk("valid_cleared_on_start", 32'(tt_valid), 32'd0);
            end
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_stim", 32'(stim), 32'd0);
                chk("abort_valid", 32'(tt_valid), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            glitch = (c == glitch_cyc);
            start  = (c == restart_cyc);
            abort  = (c == abort_cyc);
            tick();
        end
        glitch = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stim", 32'(stim), 32'd0);
        chk("rst_tt_code", 32'(tt_code), 32'd0);
        chk("rst_unstable", 32'(unstable), 32'd0);
        chk("rst_tt_valid", 32'(tt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        mode = 0;
        run_sweep(0, 0, 0, dcyc, dcnt);
        chk("nand_done_cycle", 32'(dcyc), 32'd81);
        chk("nand_done_count", 32'(dcnt), 32'd1);
        chk("nand_tt_code", 32'(tt_code), 32'hFE);
        chk("nand_unstable", 32'(unstable), 32'h00);
        chk("nand_tt_valid", 32'(tt_valid), 32'd1);
        chk("nand_busy_after", 32'(busy), 32'd0);

        mode = 1;
        run_sweep(0, 0, 0, dcyc, dcnt);
        chk("and_tt_code", 32'(tt_code), 32'h01);
        chk("and_done_cycle", 32'(dcyc), 32'd81);

        mode = 2;
        run_sweep(0, 0, 0, dcyc, dcnt);
        chk("one_tt_code", 32'(tt_code), 32'hFF);

        mode = 3;
        run_sweep(0, 0, 0, dcyc, dcnt);
        chk("zero_tt_code", 32'(tt_code), 32'h00);
        chk("zero_tt_valid", 32'(tt_valid), 32'd1);

        // Row 3 samples in cycles 38..40; a low at cycle 37 reaches the second sample.
        mode = 0;
        run_sweep(37, 0, 0, dcyc, dcnt);
        chk("glitch_tt_code", 32'(tt_code), 32'hFE);
        chk("glitch_unstable", 32'(unstable), 32'h10);

        // Row 5 settles in cycles 52..57.
        run_sweep(0, 0, 54, dcyc, dcnt);
        chk("abort_no_done", 32'(dcnt), 32'd0);
        chk("abort_keep_code", 32'(tt_code), 32'hFE);
        chk("abort_keep_unst", 32'(unstable), 32'h10);
        chk("abort_valid_after", 32'(tt_valid), 32'd0);

        run_sweep(0, 20, 0, dcyc, dcnt);
        chk("restart_done_cycle", 32'(dcyc), 32'd81);
        chk("restart_done_count", 32'(dcnt), 32'd1);
        chk("restart_tt_code", 32'(tt_code), 32'hFE);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        tick();
        chk("start_abort_idle2", 32'(busy), 32'd0);

        // Asynchronous reset between edges in the middle of a sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stim", 32'(stim), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_tt_code", 32'(tt_code), 32'd0);
        chk("arst_unstable", 32'(unstable), 32'd0);
        chk("arst_tt_valid", 32'(tt_valid), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("post_reset_no_done", 32'(dcnt), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Start presented on the first edge after release.
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        run_sweep(0, 0, 0, dcyc, dcnt);
        chk("after_reset_done_cycle", 32'(dcyc), 32'd81);
        chk("after_reset_tt_code", 32'(tt_code), 32'hFE);
        chk("after_reset_unstable", 32'(unstable), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
